// File: rtl/mp_icache_dm_if.sv
// Fetch-side and refill-side bus of the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is the CPU plus memory side.
interface mp_icache_dm_if #(
  parameter int unsigned AW = 30
);
  logic          icache_req;
  logic [AW-1:0] icache_addr;
  logic          icache_rdy;
  logic          icache_vld;
  logic [31:0]   icache_data;
  logic          icache_flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvld;
  logic [31:0]   mem_rdata;

  modport slave (
    input  icache_req, icache_addr, icache_flush, mem_gnt, mem_rvld, mem_rdata,
    output icache_rdy, icache_vld, icache_data, mem_req, mem_addr
  );

  modport master (
    output icache_req, icache_addr, icache_flush, mem_gnt, mem_rvld, mem_rdata,
    input  icache_rdy, icache_vld, icache_data, mem_req, mem_addr
  );
endinterface

// File: rtl/mp_icache_dm.sv
// Direct-mapped instruction cache: single-cycle hits, blocking line refill,
// and a flush that is deferred until any in-flight refill has been answered.
module mp_icache_dm #(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned AW         = 30
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  mp_icache_dm_if.slave  bus
);
  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = AW - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

  state_t           state;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags     [SETS];
  logic [31:0]      data_mem [SETS*LINE_WORDS];
  logic [AW-1:0]    req_addr;
  logic [OFF_W-1:0] beat_cnt;
  logic             flush_pend;
  logic             vld;
  logic             mreq;
  logic [31:0]      rd_word;
  logic [31:0]      resp_word;

  logic [TAG_W-1:0] in_tag, req_tag;
  logic [IDX_W-1:0] in_idx, req_idx;
  logic [OFF_W-1:0] in_off, req_off;
  logic             accept, hit, beat_we, last_beat, flush_req;

  assign in_tag  = bus.icache_addr[AW-1 -: TAG_W];
  assign in_idx  = bus.icache_addr[OFF_W +: IDX_W];
  assign in_off  = bus.icache_addr[OFF_W-1:0];
  assign req_tag = req_addr[AW-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];

  assign accept    = bus.icache_req && bus.icache_rdy;
  assign hit       = valid[in_idx] && (tags[in_idx] == in_tag);
  assign beat_we   = (state == FILL) && bus.mem_rvld;
  assign last_beat = beat_we && (beat_cnt == OFF_W'(LINE_WORDS - 1));
  assign flush_req = flush_pend || bus.icache_flush;

  assign bus.icache_rdy  = (state == IDLE) && !bus.icache_flush;
  assign bus.icache_vld  = vld;
  assign bus.icache_data = (state == RESP) ? resp_word : rd_word;
  assign bus.mem_req     = mreq;
  assign bus.mem_addr    = {req_addr[AW-1:OFF_W], {OFF_W{1'b0}}};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      flush_pend <= 1'b0;
      vld        <= 1'b0;
      mreq       <= 1'b0;
      beat_cnt   <= '0;
      req_addr   <= '0;
    end else begin
      vld <= 1'b0;
      // A flush outside IDLE is remembered; the RESP branch below consumes it.
      if (state != IDLE && bus.icache_flush) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.icache_flush) begin
            valid <= '0;
          end else if (accept) begin
            req_addr <= bus.icache_addr;
            if (hit) begin
              vld <= 1'b1;
            end else begin
              mreq  <= 1'b1;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            mreq     <= 1'b0;
            beat_cnt <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (beat_we) beat_cnt <= beat_cnt + OFF_W'(1);
          if (last_beat) begin
            valid[req_idx] <= !flush_req;
            vld            <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          if (flush_req) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (last_beat) tags[req_idx] <= req_tag;
    if (beat_we) data_mem[{req_idx, beat_cnt}] <= bus.mem_rdata;
    if (beat_we && beat_cnt == req_off) resp_word <= bus.mem_rdata;
    if (accept) rd_word <= data_mem[{in_idx, in_off}];
  end
endmodule

// File: tb/tb_mp_icache_dm.sv
// Randomised self-checking bench for mp_icache_dm: a line-level model of the
// cache predicts hits/misses, and a scoreboard checks every response word.
module tb_mp_icache_dm;
  localparam int unsigned AW   = 30;
  localparam int unsigned LW   = 8;
  localparam int unsigned SETS = 64;

  logic sys_clk;
  logic sys_rst_n;
  mp_icache_dm_if #(.AW(AW)) bus ();

  mp_icache_dm #(.SETS(SETS), .LINE_WORDS(LW), .AW(AW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          cached_line[SETS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory contents: line 0 holds 0xA0..0xA7, everything else is address-tagged.
  function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
    if (a[AW-1:3] == '0) return 32'hA0 + {29'd0, a[2:0]};
    return {2'b01, a};
  endfunction

  function automatic int line_of(input logic [AW-1:0] a);
    return int'(a >> 3);
  endfunction

  function automatic bit model_hit(input logic [AW-1:0] a);
    return cached_line[line_of(a) % SETS] == line_of(a);
  endfunction

  task automatic model_clear();
    foreach (cached_line[i]) cached_line[i] = -1;
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge sys_clk) begin
    if (sys_rst_n && bus.icache_vld) begin
      if (exp_q.size() == 0) check("unexpected_vld", 32'd1, 32'd0);
      else check("resp_data", bus.icache_data, exp_q.pop_front());
    end
  end

  task automatic wait_rdy();
    int unsigned n = 0;
    while (!bus.icache_rdy && n < 20) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (!bus.icache_rdy) check("rdy_timeout", 32'd0, 32'd1);
  endtask

  // One fetch including the memory side. flush_at/rst_at select a beat (-1 = none).
  task automatic fetch(input logic [AW-1:0] a, input int gnt_delay, input int flush_at, input int rst_at);
    bit             hit;
    logic [AW-1:0]  line_addr;
    hit       = model_hit(a);
    line_addr = {a[AW-1:3], 3'b000};
    wait_rdy();
    bus.icache_req  = 1'b1;
    bus.icache_addr = a;
    if (rst_at < 0) exp_q.push_back(mem_val(a));
    @(posedge sys_clk); #1;
    bus.icache_req  = 1'b0;
    bus.icache_addr = AW'($urandom);
    if (hit) begin
      @(negedge sys_clk);
      check("hit_vld", bus.icache_vld, 1);
      check("hit_no_memreq", bus.mem_req, 0);
      @(posedge sys_clk); #1;
      return;
    end
    @(negedge sys_clk);
    check("miss_memreq", bus.mem_req, 1);
    check("miss_memaddr", bus.mem_addr, line_addr);
    for (int d = 0; d < gnt_delay; d++) begin
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      check("stall_memreq", bus.mem_req, 1);
      check("stall_memaddr", bus.mem_addr, line_addr);
    end
    @(posedge sys_clk); #1;
    bus.mem_gnt = 1'b1;
    @(posedge sys_clk); #1;
    bus.mem_gnt = 1'b0;
    @(negedge sys_clk);
    check("gnt_drops_memreq", bus.mem_req, 0);
    @(posedge sys_clk); #1;
    for (int k = 0; k < int'(LW); k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge sys_clk); #1;
      end
      bus.mem_rvld  = 1'b1;
      bus.mem_rdata = mem_val(line_addr + AW'(k));
      if (k == flush_at) bus.icache_flush = 1'b1;
      @(posedge sys_clk); #1;
      bus.mem_rvld     = 1'b0;
      bus.icache_flush = 1'b0;
      if (k == rst_at) begin
        sys_rst_n = 1'b0;
        #1;
        check("rst_memreq", bus.mem_req, 0);
        check("rst_vld", bus.icache_vld, 0);
        model_clear();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        for (int j = k + 1; j < int'(LW); j++) begin
          bus.mem_rvld  = 1'b1;
          bus.mem_rdata = mem_val(line_addr + AW'(j));
          @(posedge sys_clk); #1;
        end
        bus.mem_rvld = 1'b0;
        @(negedge sys_clk);
        check("post_rst_vld", bus.icache_vld, 0);
        check("post_rst_rdy", bus.icache_rdy, 1);
        @(posedge sys_clk); #1;
        return;
      end
    end
    @(negedge sys_clk);
    check("fill_resp_vld", bus.icache_vld, 1);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("fill_vld_pulse", bus.icache_vld, 0);
    @(posedge sys_clk); #1;
    if (flush_at >= 0) model_clear();
    else cached_line[line_of(a) % SETS] = line_of(a);
  endtask

  // Consecutive-cycle requests that the model says all hit.
  task automatic stream(input logic [AW-1:0] base, input int n);
    wait_rdy();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.icache_req  = 1'b1;
        bus.icache_addr = base + AW'(i);
        exp_q.push_back(mem_val(base + AW'(i)));
      end else begin
        bus.icache_req = 1'b0;
      end
      @(negedge sys_clk);
      if (i > 0) begin
        check("stream_vld", bus.icache_vld, 1);
        check("stream_no_memreq", bus.mem_req, 0);
      end
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic flush_idle();
    bus.icache_flush = 1'b1;
    bus.icache_req   = 1'b1;
    bus.icache_addr  = 30'h3;
    #1;
    check("flush_rdy_low", bus.icache_rdy, 0);
    @(posedge sys_clk); #1;
    bus.icache_flush = 1'b0;
    bus.icache_req   = 1'b0;
    model_clear();
    @(negedge sys_clk);
    check("flush_no_vld", bus.icache_vld, 0);
    check("flush_no_memreq", bus.mem_req, 0);
    @(posedge sys_clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    model_clear();
    sys_rst_n        = 1'b0;
    bus.icache_req   = 1'b0;
    bus.icache_addr  = '0;
    bus.icache_flush = 1'b0;
    bus.mem_gnt      = 1'b0;
    bus.mem_rvld     = 1'b0;
    bus.mem_rdata    = '0;
    #3;
    check("reset_rdy", bus.icache_rdy, 1);
    check("reset_vld", bus.icache_vld, 0);
    check("reset_memreq", bus.mem_req, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    fetch(30'h5, 0, -1, -1);     // cold miss -> 0xA5
    fetch(30'h2, 0, -1, -1);     // hit -> 0xA2
    stream(30'h0, 8);            // 0xA0..0xA7 back to back
    fetch(30'h205, 1, -1, -1);   // conflict in set 0
    fetch(30'h5, 0, -1, -1);     // misses again
    flush_idle();
    fetch(30'h3, 0, -1, -1);     // miss after flush
    fetch(30'h41, 2, 4, -1);     // flush mid-fill, response still delivered
    fetch(30'h42, 0, -1, -1);    // same line misses
    fetch(30'h11, 5, -1, -1);    // long grant stall
    fetch(30'h31, 0, -1, 3);     // reset after beat 3
    fetch(30'h31, 0, -1, -1);    // same line misses

    for (int it = 0; it < 40; it++) begin
      a = AW'(($urandom_range(0, 2) << 9) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) flush_idle();
      else if ($urandom_range(0, 7) == 0) fetch(a, $urandom_range(0, 3), $urandom_range(0, 7), -1);
      else fetch(a, $urandom_range(0, 3), -1, -1);
    end

    repeat (5) @(posedge sys_clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mp_icache_dm.md
MP_ICACHE_DM -- requirements
Module: mp_icache_dm

Interface
REQ-001 Parameter SETS, 64, number of cache lines; power of two, >= 2.
REQ-002 Parameter LINE_WORDS, 8, 32-bit words per line; power of two, >= 2.
REQ-003 Parameter AW, 30, width of the word address.
REQ-004 Derived widths SHALL be: OFF_W = log2(LINE_WORDS), IDX_W = log2(SETS), TAG_W = AW - IDX_W - OFF_W.
REQ-005 Address split SHALL be {tag, index, offset}, MSB to LSB.
REQ-006 Ports SHALL be:
- sys_clk  in  1  sole clock; all state changes on the rising edge.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- icache_req  in  1  fetch request; accepted only when icache_rdy = 1.
- icache_addr  in  AW  word address of the fetch.
- icache_rdy  out  1  cache can accept a request this cycle.
- icache_vld  out  1  one-cycle pulse; icache_data is valid.
- icache_data  out  32  fetched instruction word.
- icache_flush  in  1  invalidate all lines.
- mem_req  out  1  line refill request.
- mem_addr  out  AW  line-aligned word address, offset bits = 0.
- mem_gnt  in  1  memory accepts mem_req this cycle.
- mem_rvld  in  1  refill beat valid.
- mem_rdata  in  32  refill beat data.

Function
REQ-007 Storage SHALL consist of:
- a valid bit and a TAG_W tag per set, held in flops;
- a SETS*LINE_WORDS x 32 data array with synchronous read.
REQ-008 FSM states SHALL be IDLE, REQ, FILL and RESP.
REQ-009 icache_rdy SHALL equal (state == IDLE) && !icache_flush.
REQ-010 An accepted request SHALL register its address and look up the set that cycle.
REQ-011 Hit (valid && tag match): icache_vld = 1 in the next cycle with data-array word {index, offset}, and the FSM SHALL stay in IDLE.
- Back-to-back hits SHALL sustain one request per cycle.
REQ-012 Miss: the FSM SHALL go IDLE -> REQ next cycle, and mem_req = 1 with mem_addr = {tag, index, 0}.
REQ-013 In REQ, mem_req and mem_addr SHALL be held stable until sampled with mem_gnt = 1, then REQ -> FILL.
REQ-014 In FILL, beats SHALL be consumed only when mem_rvld = 1:
- beat k writes data-array word {index, k}, k = 0 .. LINE_WORDS-1;
- a beat counter counts the writes, and mem_rvld with no beat outstanding SHALL be ignored.
REQ-015 During FILL, the beat whose k equals the requested offset SHALL be captured into a response register.
REQ-016 On the last beat, the line's tag SHALL be written and its valid bit set, unless a flush is pending (REQ-019); then FILL -> RESP.
REQ-017 In RESP, icache_vld = 1 with the captured word for exactly one cycle, then RESP -> IDLE.
REQ-018 A flush with state == IDLE SHALL clear every valid bit at the clock edge.
- A request in the same cycle is not accepted, because icache_rdy = 0.
REQ-019 A flush in REQ, FILL or RESP SHALL set a pending flag:
- the in-flight refill completes and its response is delivered;
- the refilled line is left invalid;
- all valid bits are cleared when the FSM returns to IDLE, and the flag is then cleared.
REQ-020 icache_vld SHALL be a single-cycle pulse per accepted request; there SHALL be no duplicate or dropped responses.
REQ-021 Tag, valid and data writes SHALL use only the registered request address; icache_addr changes after acceptance SHALL have no effect.

Reset
REQ-022 While sys_rst_n = 0, asynchronously:
- state = IDLE, all valid bits = 0, flush pending = 0;
- icache_vld = 0, mem_req = 0, beat counter = 0.
REQ-023 Data-array and tag contents need not be reset.
REQ-024 A reset during REQ or FILL SHALL abandon the refill, with no response.
- Beats arriving after reset release SHALL be ignored.

Verification (SETS = 64, LINE_WORDS = 8, AW = 30)
REQ-025 Cold miss: req 0x0000005 after reset ->
- mem_req with mem_addr 0x0000000;
- gnt, then beats 0xA0..0xA7 -> icache_vld with data 0xA5, one cycle after the last beat.
- Then req 0x0000002 -> icache_vld next cycle, data 0xA2, mem_req stays 0.
REQ-026 Conflict: after REQ-025, req 0x0000205 (index 0, new tag) -> refill of 0x0000200.
- Then req 0x0000005 -> miss again, mem_addr 0x0000000.
REQ-027 Hit streaming: req 0x0..0x7 on consecutive cycles after the fill -> eight consecutive icache_vld pulses, data 0xA0..0xA7 in order.
REQ-028 Flush:
- after a fill, flush for 1 cycle -> icache_rdy = 0 that cycle; then req 0x0000003 -> miss.
- flush mid-FILL -> response still delivered; a repeat request to the same line misses.
REQ-029 Stall and reset:
- mem_gnt held low for 5 cycles -> mem_req and mem_addr stable throughout.
- sys_rst_n low after beat 3 -> mem_req = 0, icache_vld = 0, no response; remaining beats ignored; next req to the same line misses.
